first_one_search_reg: RTL and testbench
=======================================

Name: first_one_search_reg

Overview:
- Registered lowest-set-bit priority encoder.
- Scans a DATA_WIDTH-bit request vector, e.g. a free-list or ready bitmap in the OoO core, and returns the index of the least-significant '1' plus a found flag.
- Result is registered, with one cycle of latency.
- Used wherever the core allocates the first free entry.

Parameters:
- DATA_WIDTH, 16, width of the searched vector; any value >= 2.
- POS_WIDTH, $clog2(DATA_WIDTH), width of the position output; must be >= $clog2(DATA_WIDTH).
- CURRENT_POS, DATA_WIDTH, search window size. Only bits [CURRENT_POS-1:0] are searched; bits above are ignored. Legal range is 1..DATA_WIDTH.

Ports:
- clk, input, 1, sole clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, qualifies data for this cycle.
- data, input, DATA_WIDTH, vector to search.
- valid, output, 1, registered; 1 when the last accepted vector had a '1' inside the window.
- position, output, POS_WIDTH, registered index of the lowest '1' in the window.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: at a rising clk edge with rst=1, valid <= 0 and position <= 0. rst has priority over in_valid.
- Search is combinational over data[CURRENT_POS-1:0]:
  - found = OR of the window bits.
  - idx = smallest i with data[i]=1; 0 if none.
- Lowest index wins: bit 0 has the highest priority.
- Update at each rising edge with rst=0:
  - in_valid=1: valid <= found, position <= idx.
  - in_valid=0: valid <= 0, position holds its previous value.
- Latency: the result for data sampled at edge N is visible after edge N, and stays stable for the whole following cycle.
- Boundary conditions:
  - All-zero window: valid=0, position=0.
  - Only the top window bit set: position=CURRENT_POS-1.
  - All bits set: position=0.
  - Bits set only at or above CURRENT_POS: valid=0, position=0.
- No X propagation from bits outside the window. Output must not depend on them.
- Implementation structure:
  - Log-depth tree: pairwise combine (found, idx) nodes; the lower half wins when its found=1; the upper-half idx gets a half-size offset.
  - Must be parameter-generic; no hard-coded 16-bit case statement.
  - Pad a non-power-of-two window with zeros internally.
- Outputs are registered only; no combinational path from inputs to outputs.

Optional Feature:
- Macro: FOS_ONEHOT_EN.
- When defined:
  - Adds output port onehot, width DATA_WIDTH.
  - Registered alongside valid, with the same reset and update rules.
  - Value is the one-hot mask of the selected bit: only bit[position] set when found, all zeros otherwise.
  - Reset value 0; cleared to 0 when in_valid=0.
  - Invariant: onehot == (valid ? 1<<position : 0).
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with data=16'hFFFF and in_valid=1 -> valid=0, position=0. After rst drops, first edge with in_valid=1 -> valid=1, position=0.
- Directed vectors with in_valid=1, CURRENT_POS=16, each checked one cycle later:
  - data=16'b0000_1001_0000_0001 -> valid=1, position=0.
  - data=16'b0000_1000_1000_0010 -> valid=1, position=1.
  - data=16'b0000_1000_0100_0100 -> valid=1, position=2.
  - data=16'b1000_0000_0000_1000 -> valid=1, position=3.
- Extremes:
  - data=16'h0000 -> valid=0, position=0.
  - data=16'h8000 -> valid=1, position=15.
  - data=16'hFFFF -> valid=1, position=0.
- Hold: load 16'h0010 (position=4), then in_valid=0 with data=16'h0001 -> valid=0, position stays 4.
- Window: CURRENT_POS=8, DATA_WIDTH=16:
  - data=16'h0100 -> valid=0, position=0.
  - data=16'h0180 -> valid=1, position=7.
- Random: 1000 random vectors with random in_valid, compared against a reference loop model. With FOS_ONEHOT_EN, also check onehot == (valid ? 1<<position : 0).

Source files
------------

// File: rtl/first_one_search_reg.sv
// first_one_search_reg
// Registered lowest-set-bit priority encoder. It scans data[CURRENT_POS-1:0]
// and returns the index of the least-significant '1' and a found flag, with
// one cycle of latency. Typical use is picking the first free entry from a
// free-list or ready bitmap.
//
// Optional build macro: FOS_ONEHOT_EN adds a registered one-hot output of the
// selected bit. When the macro is not defined, the onehot port and its logic
// are not built.
module first_one_search_reg #(
  parameter int DATA_WIDTH  = 16,
  parameter int POS_WIDTH   = $clog2(DATA_WIDTH),
  parameter int CURRENT_POS = DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] data,
`ifdef FOS_ONEHOT_EN
  output logic [DATA_WIDTH-1:0] onehot,
`endif
  output logic                  valid,
  output logic [POS_WIDTH-1:0]  position
);

  // The tree always has at least one combining level, so that a one-bit
  // window still gives an index field that is one bit wide.
  localparam int TREE_LVLS = (CURRENT_POS > 1) ? $clog2(CURRENT_POS) : 1;
  localparam int NPAD      = 1 << TREE_LVLS;

  logic [NPAD-1:0]      w_win_p0;
  logic                 w_fnd_p0 [NPAD];
  logic [TREE_LVLS-1:0] w_idx_p0 [NPAD];
  logic                 w_found_p0;
  logic [TREE_LVLS-1:0] w_pos_p0;

  logic                 r_vld_p1;
  logic [POS_WIDTH-1:0] r_position_p1;

  // Bits at or above CURRENT_POS never reach the tree. This sink only keeps
  // them referenced, and it drives no logic.
  logic w_unused;
  assign w_unused = ^data;

  // Build the window, padded to a power of two with zeros, and reduce it
  // through a log-depth tree of (found, idx) nodes. At each level a node at
  // slot j merges with its upper sibling at slot j+span. The lower child wins
  // whenever it found a '1'. Otherwise the upper child's index is moved up by
  // span. The result of each merge goes back into slot j.
  always_comb begin
    w_win_p0 = '0;
    for (int i = 0; i < CURRENT_POS; i++) begin
      w_win_p0[i] = data[i];
    end
    for (int i = 0; i < NPAD; i++) begin
      w_fnd_p0[i] = w_win_p0[i];
      w_idx_p0[i] = '0;
    end
    for (int l = 0; l < TREE_LVLS; l++) begin
      for (int j = 0; j < NPAD; j += (2 << l)) begin
        if (!w_fnd_p0[j] && w_fnd_p0[j + (1 << l)]) begin
          w_idx_p0[j] = w_idx_p0[j + (1 << l)] + TREE_LVLS'(1 << l);
        end
        w_fnd_p0[j] = w_fnd_p0[j] | w_fnd_p0[j + (1 << l)];
      end
    end
    w_found_p0 = w_fnd_p0[0];
    w_pos_p0   = w_idx_p0[0];
  end

  // Result register. Reset takes priority over in_valid. When no vector is
  // presented, valid drops and position keeps its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1      <= 1'b0;
      r_position_p1 <= '0;
    end else if (in_valid) begin
      r_vld_p1      <= w_found_p0;
      r_position_p1 <= POS_WIDTH'(w_pos_p0);
    end else begin
      r_vld_p1      <= 1'b0;
    end
  end

  assign valid    = r_vld_p1;
  assign position = r_position_p1;

`ifdef FOS_ONEHOT_EN
  logic [DATA_WIDTH-1:0] r_onehot_p1;

  // One-hot mask of the selected bit. It is registered together with valid,
  // so the mask is all zeros whenever valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_onehot_p1 <= '0;
    end else if (in_valid && w_found_p0) begin
      r_onehot_p1 <= DATA_WIDTH'(1) << w_pos_p0;
    end else begin
      r_onehot_p1 <= '0;
    end
  end

  assign onehot = r_onehot_p1;
`endif

endmodule

// File: tb/tb_first_one_search_reg.sv
// Testbench for first_one_search_reg. It builds a full-window instance (16/16)
// and a narrow-window instance (16/8) that share the same input stimulus.
module tb_first_one_search_reg;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] data;

  logic        valid_f, valid_w;
  logic [3:0]  pos_f, pos_w;
`ifdef FOS_ONEHOT_EN
  logic [15:0] oh_f, oh_w;
`endif

  int n_chk = 0;
  int n_bad = 0;

  first_one_search_reg #(.DATA_WIDTH(16), .POS_WIDTH(4), .CURRENT_POS(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .data     (data),
`ifdef FOS_ONEHOT_EN
    .onehot   (oh_f),
`endif
    .valid    (valid_f),
    .position (pos_f)
  );

  first_one_search_reg #(.DATA_WIDTH(16), .POS_WIDTH(4), .CURRENT_POS(8)) dut_w (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .data     (data),
`ifdef FOS_ONEHOT_EN
    .onehot   (oh_w),
`endif
    .valid    (valid_w),
    .position (pos_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Drive the inputs on the falling edge, then sample 1 time unit after the
  // next rising edge.
  task automatic apply(input logic r, input logic iv, input logic [15:0] d);
    @(negedge clk);
    rst      = r;
    in_valid = iv;
    data     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic vec_f(input string tag, input logic [15:0] d, input logic ev, input logic [3:0] ep);
    apply(1'b0, 1'b1, d);
    chk({tag, ".valid"}, {31'd0, valid_f}, {31'd0, ev});
    chk({tag, ".pos"}, {28'd0, pos_f}, {28'd0, ep});
`ifdef FOS_ONEHOT_EN
    chk({tag, ".oh"}, {16'd0, oh_f}, ev ? (32'd1 << ep) : 32'd0);
`endif
  endtask

  // Reference: a straight linear scan for the lowest '1' below win.
  function automatic logic [4:0] ref_scan(input logic [15:0] d, input int win);
    for (int i = 0; i < win; i++) begin
      if (d[i]) return {1'b1, 4'(i)};
    end
    return 5'd0;
  endfunction

  logic       m_v, mw_v;
  logic [3:0] m_p, mw_p;
  logic [4:0] r_f, r_w;
  logic [15:0] rd;
  logic        riv;

  initial begin
    rst = 1'b0; in_valid = 1'b0; data = '0;

    // Reset is held with an all-ones vector present and in_valid=1.
    apply(1'b1, 1'b1, 16'hFFFF);
    apply(1'b1, 1'b1, 16'hFFFF);
    chk("rst.valid", {31'd0, valid_f}, 32'd0);
    chk("rst.pos", {28'd0, pos_f}, 32'd0);
    chk("rst.valid_w", {31'd0, valid_w}, 32'd0);
`ifdef FOS_ONEHOT_EN
    chk("rst.oh", {16'd0, oh_f}, 32'd0);
`endif
    vec_f("first", 16'hFFFF, 1'b1, 4'd0);

    vec_f("d0", 16'b0000_1001_0000_0001, 1'b1, 4'd0);
    vec_f("d1", 16'b0000_1000_1000_0010, 1'b1, 4'd1);
    vec_f("d2", 16'b0000_1000_0100_0100, 1'b1, 4'd2);
    vec_f("d3", 16'b1000_0000_0000_1000, 1'b1, 4'd3);

    vec_f("zero", 16'h0000, 1'b0, 4'd0);
    vec_f("top", 16'h8000, 1'b1, 4'd15);
    vec_f("ones", 16'hFFFF, 1'b1, 4'd0);

    // Hold: position keeps its value while in_valid is low.
    vec_f("load4", 16'h0010, 1'b1, 4'd4);
    apply(1'b0, 1'b0, 16'h0001);
    chk("hold.valid", {31'd0, valid_f}, 32'd0);
    chk("hold.pos", {28'd0, pos_f}, 32'd4);
`ifdef FOS_ONEHOT_EN
    chk("hold.oh", {16'd0, oh_f}, 32'd0);
`endif

    // Window of 8 bits on the second instance.
    apply(1'b0, 1'b1, 16'h0100);
    chk("win.out.valid", {31'd0, valid_w}, 32'd0);
    chk("win.out.pos", {28'd0, pos_w}, 32'd0);
    chk("win.full.pos", {28'd0, pos_f}, 32'd8);
    apply(1'b0, 1'b1, 16'h0180);
    chk("win.top.valid", {31'd0, valid_w}, 32'd1);
    chk("win.top.pos", {28'd0, pos_w}, 32'd7);
`ifdef FOS_ONEHOT_EN
    chk("win.top.oh", {16'd0, oh_w}, 32'h80);
`endif

    // Bring both models to a known state, then run the random vectors.
    apply(1'b0, 1'b1, 16'h0000);
    m_v = 1'b0; m_p = 4'd0; mw_v = 1'b0; mw_p = 4'd0;
    for (int k = 0; k < 1000; k++) begin
      rd  = 16'($urandom);
      if (k % 4 == 0) rd = rd & 16'($urandom);
      if (k % 8 == 0) rd = rd & 16'hFF00;
      riv = 1'($urandom_range(0, 1));
      r_f = ref_scan(rd, 16);
      r_w = ref_scan(rd, 8);
      if (riv) begin
        m_v = r_f[4]; m_p = r_f[3:0];
        mw_v = r_w[4]; mw_p = r_w[3:0];
      end else begin
        m_v = 1'b0; mw_v = 1'b0;
      end
      apply(1'b0, riv, rd);
      chk("rnd.valid", {31'd0, valid_f}, {31'd0, m_v});
      chk("rnd.pos", {28'd0, pos_f}, {28'd0, m_p});
      chk("rnd.valid_w", {31'd0, valid_w}, {31'd0, mw_v});
      chk("rnd.pos_w", {28'd0, pos_w}, {28'd0, mw_p});
`ifdef FOS_ONEHOT_EN
      chk("rnd.oh", {16'd0, oh_f}, m_v ? (32'd1 << m_p) : 32'd0);
      chk("rnd.oh_w", {16'd0, oh_w}, mw_v ? (32'd1 << mw_p) : 32'd0);
`endif
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
